address_scanner: RTL and testbench
==================================

# address_scanner

Sequential address source that sits directly upstream of the `decoder` block. It walks `out_address` through the enabled channels in round-robin order and holds each address for a programmable dwell time, producing the scan pattern for display-digit or row multiplexing. It also watches the decoder's `out_error` and latches a fault if the decoder ever rejects an address.

## Interface
- `NUM_OUTPUT`, default 4: number of decoder outputs; must be ≥2. `ADDR_W = $clog2(NUM_OUTPUT)`.
- `DWELL_CYCLES`, default 4: cycles each address is presented with `out_valid` high; must be ≥1.
- `BLANK_CYCLES`, default 1: gap cycles between channels; used only when blanking is compiled in; must be ≥1.
- `clk`  in  1  system clock; the block's only clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_enable`  in  1  scanning runs while high.
- `in_mask`  in  NUM_OUTPUT  bit i high means channel i is included in the scan.
- `in_error`  in  1  connects to the decoder's `out_error`.
- `in_clear`  in  1  acknowledges a fault and returns the block to IDLE.
- `out_address`  out  ADDR_W  connects to the decoder's `in_address`.
- `out_valid`  out  1  high while `out_address` is being displayed.
- `out_wrap`  out  1  one-cycle pulse when the scan restarts from the lowest enabled channel.
- `out_fault`  out  1  high while the block is in FAULT.

## Operation
- **States:** IDLE, SCAN, BLANK (only when blanking is compiled in), FAULT.
- **Reset:** on an `rst_n` low edge, every output goes to 0 and the state goes to IDLE. Reset wins over every other input, including mid-scan and in FAULT.
- **IDLE**
  - If `in_enable`=1 and `in_mask`≠0, go to SCAN.
  - On entry to SCAN: `out_address` = lowest set mask bit, `out_valid`=1, dwell counter=0.
  - If the mask is all zeros, stay in IDLE.
- **SCAN**
  - The dwell counter runs 0..DWELL_CYCLES-1.
  - At terminal count, sample `in_mask` and select the next set bit strictly above the current address. If there is none, select the lowest set bit; this is a wrap.
  - Without blanking, `out_address` updates at that edge and the counter restarts.
- **Advance with mask = 0:** go to IDLE with `out_valid`=0.
- **Single set bit:** the block advances to the same address. `out_wrap` pulses every dwell period.
- **Mask changes mid-dwell:** ignored until the next advance.
- **`in_enable` low** in SCAN or BLANK: go to IDLE at the next edge. `out_valid`=0 and `out_address` holds its value. Re-enabling restarts from the lowest set bit.
- **Errors**
  - `in_error`=1 in any cycle with `out_valid`=1 sends the block to FAULT at the next edge.
  - In FAULT: `out_valid`=0, `out_fault`=1, and `out_address` is frozen at the offending value.
  - `in_error` is ignored while `out_valid`=0.
- **FAULT:** leaves only on `in_clear`=1, going to IDLE with `out_fault`=0. `in_clear` is ignored in all other states.
- **Priority, same cycle:** reset > `in_error` > `in_enable` low > advance.
- **Address range:** addresses ≥ NUM_OUTPUT are never generated. Mask bits beyond NUM_OUTPUT do not exist.

## Timing
- `out_valid` rises 1 cycle after `in_enable`=1 is sampled in IDLE.
- Each channel is valid for exactly DWELL_CYCLES cycles.
- Channel period:
  - without blanking: DWELL_CYCLES;
  - with blanking: DWELL_CYCLES + BLANK_CYCLES.
- `out_wrap` is high in the first valid cycle of the wrapped address.
- `out_fault` rises 1 cycle after the `in_error` sample.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- **`SCANNER_BLANKING_EN` defined**
  - At each advance the block enters BLANK for BLANK_CYCLES cycles with `out_valid`=0.
  - `out_address` holds the old value during BLANK.
  - The new address, `out_valid`=1 and any `out_wrap` all appear together on entry to SCAN.
  - `in_enable` low during BLANK goes to IDLE.
- **Not defined:** the BLANK state and its counter are absent, and the block advances back-to-back.

## Structure
- **Shared package/header `scanner_pkg`:**
  - state encoding constants IDLE=0, SCAN=1, BLANK=2, FAULT=3;
  - the `ADDR_W` computation.
- **Sub-module `scan_next_sel`:** combinational next-set-bit finder. Inputs are mask and current address; outputs are next address, wrap flag and none flag. It is reused by both the advance path and the IDLE start path.
- **Top level:** FSM, dwell counter and blank counter.

## Test plan
All scenarios use NUM_OUTPUT=4, DWELL_CYCLES=2 and blanking off unless stated.
- **Full scan:** mask=4'b1111, enable → addresses 0,0,1,1,2,2,3,3,0,0. `out_wrap` is high only in the first cycle of the second 0. `out_valid` rises 1 cycle after enable.
- **Sparse and single masks:**
  - mask=4'b1010 → 1,1,3,3,1 with wrap on the return to 1.
  - mask=4'b0100 → constant 2, with `out_wrap` every 2nd cycle.
  - mask=0 → the block stays in IDLE with `out_valid`=0.
- **Fault:** force `in_error`=1 for one cycle while the address is 2 → next cycle `out_fault`=1, `out_valid`=0, address stays 2. `in_clear` pulse → IDLE. Re-enable restarts at 0.
- **Disable and reset mid-scan:**
  - Drop `in_enable` while the address is 1 → next cycle `out_valid`=0 and the address holds 1.
  - Pulse `rst_n` low while in FAULT → all outputs 0 and state IDLE.
- **Blanking:** with `SCANNER_BLANKING_EN`, BLANK_CYCLES=1 → pattern (addr,valid) = (0,1),(0,1),(0,0),(1,1),(1,1),(1,0),(2,1). `in_error` injected during the blank cycle is ignored.

Source files
------------

// File: rtl/scanner_pkg.sv
// Shared definitions for the address scanner: state encoding and width helpers.
package scanner_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2,
        FAULT = 2'd3
    } state_e;

    // Width of a field holding 0..n-1; never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scan_next_sel.sv
// Combinational next-set-bit finder: picks the next enabled channel strictly above
// cur_addr_i (or the lowest enabled one when from_start_i), flagging wrap and empty mask.
import scanner_pkg::*;

module scan_next_sel #(
    parameter int NUM_OUTPUT = 4,
    parameter int ADDR_W     = addr_w(NUM_OUTPUT)
) (
    input  logic [NUM_OUTPUT-1:0] mask_i,
    input  logic [ADDR_W-1:0]     cur_addr_i,
    input  logic                  from_start_i,
    output logic [ADDR_W-1:0]     next_addr_o,
    output logic                  wrap_o,
    output logic                  none_o
);

    logic [ADDR_W-1:0] lo_addr;
    logic [ADDR_W-1:0] hi_addr;
    logic              found_lo;
    logic              found_hi;

    always_comb begin
        lo_addr  = '0;
        hi_addr  = '0;
        found_lo = 1'b0;
        found_hi = 1'b0;
        // Descending walk so the last hit is the lowest qualifying bit.
        for (int i = NUM_OUTPUT - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                lo_addr  = ADDR_W'(i);
                found_lo = 1'b1;
                if (ADDR_W'(i) > cur_addr_i) begin
                    hi_addr  = ADDR_W'(i);
                    found_hi = 1'b1;
                end
            end
        end
    end

    assign none_o      = !found_lo;
    assign next_addr_o = (found_hi && !from_start_i) ? hi_addr : lo_addr;
    assign wrap_o      = found_lo && !found_hi && !from_start_i;

endmodule

// File: rtl/address_scanner.sv
// Round-robin address source for the decoder with dwell timing and fault latching.
// Optional inter-channel blanking is compiled in with SCANNER_BLANKING_EN.
import scanner_pkg::*;

module address_scanner #(
    parameter int NUM_OUTPUT   = 4,
    parameter int DWELL_CYCLES = 4,
    parameter int BLANK_CYCLES = 1,
    parameter int ADDR_W       = addr_w(NUM_OUTPUT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_enable,
    input  logic [NUM_OUTPUT-1:0] in_mask,
    input  logic                  in_error,
    input  logic                  in_clear,
    output logic [ADDR_W-1:0]     out_address,
    output logic                  out_valid,
    output logic                  out_wrap,
    output logic                  out_fault
);

    localparam int DW = addr_w(DWELL_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              valid_q;
    logic              wrap_q;
    logic              fault_q;
    logic [DW-1:0]     dwell_q;

    logic [ADDR_W-1:0] sel_addr_d;
    logic              sel_wrap_d;
    logic              sel_none_d;

`ifdef SCANNER_BLANKING_EN
    localparam int BW = addr_w(BLANK_CYCLES);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

    logic [BW-1:0]     blank_q;
    logic [ADDR_W-1:0] pend_addr_q;
    logic              pend_wrap_q;
`endif

    // Outside SCAN the selector searches from the bottom, giving the start address.
    scan_next_sel #(
        .NUM_OUTPUT (NUM_OUTPUT),
        .ADDR_W     (ADDR_W)
    ) u_sel (
        .mask_i       (in_mask),
        .cur_addr_i   (addr_q),
        .from_start_i (state_q != SCAN),
        .next_addr_o  (sel_addr_d),
        .wrap_o       (sel_wrap_d),
        .none_o       (sel_none_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            fault_q <= 1'b0;
            dwell_q <= '0;
`ifdef SCANNER_BLANKING_EN
            blank_q     <= '0;
            pend_addr_q <= '0;
            pend_wrap_q <= 1'b0;
`endif
        end else begin
            wrap_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_enable && !sel_none_d) begin
                        state_q <= SCAN;
                        addr_q  <= sel_addr_d;
                        valid_q <= 1'b1;
                        dwell_q <= '0;
                    end
                end
                SCAN: begin
                    if (in_error) begin
                        state_q <= FAULT;
                        valid_q <= 1'b0;
                        fault_q <= 1'b1;
                    end else if (!in_enable) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end else if (dwell_q == DWELL_LAST) begin
                        dwell_q <= '0;
                        if (sel_none_d) begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                        end else begin
`ifdef SCANNER_BLANKING_EN
                            // Next channel is chosen now but only shown after the gap.
                            state_q     <= BLANK;
                            valid_q     <= 1'b0;
                            blank_q     <= '0;
                            pend_addr_q <= sel_addr_d;
                            pend_wrap_q <= sel_wrap_d;
`else
                            addr_q <= sel_addr_d;
                            wrap_q <= sel_wrap_d;
`endif
                        end
                    end else begin
                        dwell_q <= dwell_q + DW'(1);
                    end
                end
`ifdef SCANNER_BLANKING_EN
                BLANK: begin
                    if (!in_enable) begin
                        state_q <= IDLE;
                    end else if (blank_q == BLANK_LAST) begin
                        state_q <= SCAN;
                        addr_q  <= pend_addr_q;
                        valid_q <= 1'b1;
                        wrap_q  <= pend_wrap_q;
                        dwell_q <= '0;
                    end else begin
                        blank_q <= blank_q + BW'(1);
                    end
                end
`endif
                FAULT: begin
                    if (in_clear) begin
                        state_q <= IDLE;
                        fault_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_address = addr_q;
    assign out_valid   = valid_q;
    assign out_wrap    = wrap_q;
    assign out_fault   = fault_q;

endmodule

// File: tb/tb_address_scanner.sv
// Directed per-cycle vector bench for address_scanner (NUM_OUTPUT=4, DWELL_CYCLES=2,
// BLANK_CYCLES=1); the blanking vectors are used when SCANNER_BLANKING_EN is defined.
module tb_address_scanner;

    localparam int NUM_OUTPUT   = 4;
    localparam int DWELL_CYCLES = 2;
    localparam int BLANK_CYCLES = 1;
`ifdef SCANNER_BLANKING_EN
    localparam int PERIOD = DWELL_CYCLES + BLANK_CYCLES;
`else
    localparam int PERIOD = DWELL_CYCLES;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_enable = 1'b0;
    logic [3:0] in_mask = 4'b0000;
    logic       in_error = 1'b0;
    logic       in_clear = 1'b0;
    logic [1:0] out_address;
    logic       out_valid;
    logic       out_wrap;
    logic       out_fault;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    address_scanner #(
        .NUM_OUTPUT   (NUM_OUTPUT),
        .DWELL_CYCLES (DWELL_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_enable   (in_enable),
        .in_mask     (in_mask),
        .in_error    (in_error),
        .in_clear    (in_clear),
        .out_address (out_address),
        .out_valid   (out_valid),
        .out_wrap    (out_wrap),
        .out_fault   (out_fault)
    );

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [3:0] mask;
        logic       err;
        logic       clr;
        logic [1:0] addr;
        logic       valid;
        logic       wrap;
        logic       fault;
    } vec_t;

    vec_t vecs[$];

    // Inputs applied before an edge, outputs expected just after it.
    task automatic add(input logic r, input logic e, input logic [3:0] m,
                       input logic er, input logic c, input logic [1:0] a,
                       input logic v, input logic w, input logic f);
        vec_t t;
        t.rst_n = r; t.en = e; t.mask = m; t.err = er; t.clr = c;
        t.addr = a; t.valid = v; t.wrap = w; t.fault = f;
        vecs.push_back(t);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end else begin
            $display("[TB] %s ok: %0d", name, got);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int w1;
        int w2;
        //   rst en mask     err clr  addr v w f
        add(0, 0, 4'b0000, 0, 0, 2'd0, 0, 0, 0);
        add(1, 0, 4'b1111, 0, 0, 2'd0, 0, 0, 0);
`ifdef SCANNER_BLANKING_EN
        add(1, 1, 4'b1111, 0, 0, 2'd0, 1, 0, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd0, 1, 0, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd0, 0, 0, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd1, 1, 0, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd1, 1, 0, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd1, 0, 0, 0);
        add(1, 1, 4'b1111, 1, 0, 2'd2, 1, 0, 0);  // error during blank ignored
        add(1, 1, 4'b1111, 0, 0, 2'd2, 1, 0, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd2, 0, 0, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd3, 1, 0, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd3, 1, 0, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd3, 0, 0, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd0, 1, 1, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd0, 1, 0, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd0, 0, 0, 0);
        add(1, 0, 4'b1111, 0, 0, 2'd0, 0, 0, 0);  // disable in blank
        add(1, 1, 4'b1111, 0, 0, 2'd0, 1, 0, 0);
        add(1, 1, 4'b1111, 1, 0, 2'd0, 0, 0, 1);
        add(0, 1, 4'b1111, 0, 0, 2'd0, 0, 0, 0);
`else
        // full scan
        add(1, 1, 4'b1111, 0, 0, 2'd0, 1, 0, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd0, 1, 0, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd1, 1, 0, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd1, 1, 0, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd2, 1, 0, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd2, 1, 0, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd3, 1, 0, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd3, 1, 0, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd0, 1, 1, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd0, 1, 0, 0);
        add(1, 0, 4'b1111, 0, 0, 2'd0, 0, 0, 0);
        // sparse mask 1010
        add(1, 1, 4'b1010, 0, 0, 2'd1, 1, 0, 0);
        add(1, 1, 4'b1010, 0, 0, 2'd1, 1, 0, 0);
        add(1, 1, 4'b1010, 0, 0, 2'd3, 1, 0, 0);
        add(1, 1, 4'b1010, 0, 0, 2'd3, 1, 0, 0);
        add(1, 1, 4'b1010, 0, 0, 2'd1, 1, 1, 0);
        add(1, 1, 4'b1010, 0, 0, 2'd1, 1, 0, 0);
        // single bit 0100, sampled at the advance
        add(1, 1, 4'b0100, 0, 0, 2'd2, 1, 0, 0);
        add(1, 1, 4'b0100, 0, 0, 2'd2, 1, 0, 0);
        add(1, 1, 4'b0100, 0, 0, 2'd2, 1, 1, 0);
        add(1, 1, 4'b0100, 0, 0, 2'd2, 1, 0, 0);
        add(1, 1, 4'b0100, 0, 0, 2'd2, 1, 1, 0);
        // mask cleared mid-dwell, then advance with empty mask
        add(1, 1, 4'b0000, 0, 0, 2'd2, 1, 0, 0);
        add(1, 1, 4'b0000, 0, 0, 2'd2, 0, 0, 0);
        add(1, 1, 4'b0000, 0, 0, 2'd2, 0, 0, 0);
        // fault at address 2
        add(1, 1, 4'b1111, 0, 0, 2'd0, 1, 0, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd0, 1, 0, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd1, 1, 0, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd1, 1, 0, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd2, 1, 0, 0);
        add(1, 1, 4'b1111, 1, 0, 2'd2, 0, 0, 1);
        add(1, 1, 4'b1111, 0, 0, 2'd2, 0, 0, 1);
        add(1, 1, 4'b1111, 0, 1, 2'd2, 0, 0, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd0, 1, 0, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd0, 1, 0, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd1, 1, 0, 0);
        // disable while at address 1, error ignored while not valid
        add(1, 0, 4'b1111, 0, 0, 2'd1, 0, 0, 0);
        add(1, 0, 4'b1111, 1, 0, 2'd1, 0, 0, 0);
        add(1, 0, 4'b1111, 0, 1, 2'd1, 0, 0, 0);
        // reset while in FAULT
        add(1, 1, 4'b1111, 0, 0, 2'd0, 1, 0, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd0, 1, 0, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd1, 1, 0, 0);
        add(1, 1, 4'b1111, 1, 0, 2'd1, 0, 0, 1);
        add(0, 1, 4'b1111, 0, 1, 2'd0, 0, 0, 0);
        add(1, 0, 4'b1111, 0, 0, 2'd0, 0, 0, 0);
        // error beats enable low in the same cycle
        add(1, 1, 4'b1111, 0, 0, 2'd0, 1, 0, 0);
        add(1, 0, 4'b1111, 1, 0, 2'd0, 0, 0, 1);
        add(1, 0, 4'b1111, 0, 1, 2'd0, 0, 0, 0);
        // reset mid-scan
        add(1, 1, 4'b1111, 0, 0, 2'd0, 1, 0, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd0, 1, 0, 0);
        add(1, 1, 4'b1111, 0, 0, 2'd1, 1, 0, 0);
        add(0, 1, 4'b1111, 0, 0, 2'd0, 0, 0, 0);
`endif

        foreach (vecs[i]) begin
            rst_n     = vecs[i].rst_n;
            in_enable = vecs[i].en;
            in_mask   = vecs[i].mask;
            in_error  = vecs[i].err;
            in_clear  = vecs[i].clr;
            step();
            n_tests++;
            if (out_address !== vecs[i].addr || out_valid !== vecs[i].valid ||
                out_wrap !== vecs[i].wrap || out_fault !== vecs[i].fault) begin
                n_fail++;
                $display("FAIL vec%0d: got addr=%0d valid=%0b wrap=%0b fault=%0b, expected addr=%0d valid=%0b wrap=%0b fault=%0b",
                         i, out_address, out_valid, out_wrap, out_fault,
                         vecs[i].addr, vecs[i].valid, vecs[i].wrap, vecs[i].fault);
            end else begin
                $display("[TB] vec%0d ok: addr=%0d valid=%0b wrap=%0b fault=%0b",
                         i, out_address, out_valid, out_wrap, out_fault);
            end
        end

        // Wrap cadence on a single-channel mask, bounded by a cycle budget.
        rst_n = 1'b0; in_enable = 1'b0; in_error = 1'b0; in_clear = 1'b0;
        step();
        rst_n = 1'b1; in_enable = 1'b1; in_mask = 4'b1000;
        w1 = -1;
        w2 = -1;
        for (int c = 0; c < 30; c++) begin
            step();
            if (out_wrap === 1'b1) begin
                if (w1 < 0) w1 = c;
                else if (w2 < 0) w2 = c;
            end
        end
        check("single_bit_addr", int'(out_address), 3);
        check("first_wrap_cycle", w1, PERIOD);
        check("wrap_interval", (w2 < 0) ? -1 : (w2 - w1), PERIOD);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
